memory_bus_bridge: RTL and testbench
====================================

# memory_bus_bridge

Converts the compute core's single-cycle data-memory port (MemEn/MemWrite/ByteEn/MemAdr/MemWriteData → MemReadData) into a valid/ready request plus response transaction on an external variable-latency memory bus. It sits directly downstream of the core's M stage. It freezes the core with Stall until the access completes, and reports illegal byte-enable masks, bus errors and timeouts through a one-cycle MemFault pulse.

## Interface
- BIT_COUNT, 32, address width (32 or 64)
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before the access faults
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; state is reset on a rising edge of clk where reset==0
- MemEn  in  1  core requests a data access this cycle
- MemWrite  in  1  1 = store, 0 = load
- ByteEn  in  4  lane mask, already positioned on the 32-bit word
- MemAdr  in  BIT_COUNT  byte address
- MemWriteData  in  32  store data, lane-positioned
- MemReadData  out  32  registered load data to the core
- Stall  out  1  core must hold all state and inputs stable while high
- MemFault  out  1  one-cycle pulse; the access was aborted
- BusReqValid  out  1  request valid
- BusReqReady  in  1  bus accepts request
- BusWrite  out  1  request is a store
- BusByteEn  out  4  request lane mask
- BusAdr  out  BIT_COUNT  word-aligned address: MemAdr with [1:0] forced to 0
- BusWriteData  out  32  store data
- BusRespValid  in  1  response present (load data or store ack)
- BusRespData  in  32  load data
- BusRespError  in  1  bus error, qualified by BusRespValid

## Operation
- FSM states are IDLE, REQ, WAIT, DONE and FAULT. Reset enters IDLE.
- IDLE:
  - MemEn=0: stay in IDLE.
  - MemEn=1 with a legal ByteEn: capture MemWrite, ByteEn, BusAdr and MemWriteData into the request registers, then go to REQ.
  - MemEn=1 with an illegal ByteEn: go to FAULT with no bus activity.
- Legal ByteEn values are 0001, 0010, 0100, 1000, 0011, 1100 and 1111. All others, including 0000, are illegal.
- REQ: BusReqValid=1 and the request registers drive the bus. When BusReqValid && BusReqReady, clear the timeout counter and go to WAIT. The request is held indefinitely while the bus is not ready; no timeout applies in REQ.
- WAIT:
  - BusRespValid && !BusRespError: a load captures BusRespData into MemReadData; a store leaves MemReadData unchanged. Go to DONE.
  - BusRespValid && BusRespError: go to FAULT.
  - Otherwise increment the counter. If the counter equals TIMEOUT_CYCLES, go to FAULT.
- DONE: Stall=0 so the core retires the instruction. Return unconditionally to IDLE.
- FAULT: Stall=0, MemFault=1 and MemReadData is set to 0. Return unconditionally to IDLE.
- Stall = reset && MemEn && (state ∈ {IDLE, REQ, WAIT}).
- BusRespValid in IDLE, REQ, DONE or FAULT is ignored; late responses are dropped.
- The BIT_COUNT=64 path uses the same 32-bit data lanes. Only the address widens.

## Timing
- Reset values:
  - state IDLE, counter 0
  - MemReadData 0, MemFault 0
  - BusReqValid 0, BusWrite 0, BusByteEn 0, BusAdr 0, BusWriteData 0
  - Stall 0 (gated combinationally while reset is low)
- BusReqValid and MemFault are registered; they reflect the state, not the inputs.
- Minimum access: capture in cycle 0, handshake in cycle 1, response in cycle 2, DONE in cycle 3. Stall is high for cycles 0–2 and low in cycle 3, so the penalty is 3 cycles.
- A response cannot complete in the handshake cycle. The bus guarantees the response arrives at least one cycle after acceptance.
- A new MemEn in the cycle after DONE or FAULT starts a fresh access from IDLE. There are no back-to-back bubbles beyond the IDLE capture.
- Reset low mid-access (REQ or WAIT): the next edge returns to IDLE and BusReqValid drops, abandoning the outstanding transaction. Any later response is ignored.
- Timeout: FAULT is entered on the edge where the counter reaches TIMEOUT_CYCLES, that is, TIMEOUT_CYCLES+1 cycles after WAIT entry with no response.

## Structure
- Add enum memBridgeState {IDLE, REQ, WAIT, DONE, FAULT} to the HighLevelControl package.
- The counter width is $clog2(TIMEOUT_CYCLES+1).
- Sub-module byteEnChecker is combinational: input ByteEn, output Legal. It is reused later by the load/store unit.
- The request registers, counter and FSM live in memory_bus_bridge.

## Test plan
- Load, ready immediately, response 1 cycle after handshake with data 0xDEADBEEF at MemAdr 0x100, ByteEn 1111:
  - BusAdr=0x100 for exactly one handshake cycle.
  - Stall is high for 3 cycles.
  - MemReadData=0xDEADBEEF in the DONE cycle.
- Store at MemAdr 0x203, ByteEn 1000, data 0xAA000000, BusReqReady held low 4 cycles:
  - BusReqValid is held with BusAdr=0x200.
  - No timeout occurs.
  - The ack yields DONE and MemReadData is unchanged.
- ByteEn 0101 with MemEn=1:
  - BusReqValid never rises.
  - The MemFault pulse arrives one cycle later and MemReadData=0.
- TIMEOUT_CYCLES=4 and no response after the handshake:
  - FAULT is entered 5 cycles after WAIT entry.
  - A response arriving afterwards is ignored and the state stays IDLE.
- BusRespError=1 with the response: FAULT, MemFault=1 and MemReadData=0.
- Reset driven low for one cycle during WAIT:
  - The next cycle is IDLE with BusReqValid=0 and Stall=0.
  - A stale response on the following cycle does not change MemReadData.

Source files
------------

// File: rtl/memory_bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// HighLevelControl
//   Shared control-path types for the core's memory-side blocks.
//   memBridgeState : FSM states of memory_bus_bridge.
//   LANE_COUNT     : number of byte lanes on the 32-bit data word.
//   DATA_WIDTH     : width of the data lanes; it stays 32 bits even on 64-bit
//                    address builds.
// -----------------------------------------------------------------------------
package HighLevelControl;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } memBridgeState;

    localparam int LANE_COUNT = 4;
    localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/memory_bus_bridge_byte_en_checker.sv
// -----------------------------------------------------------------------------
// byteEnChecker
//   Combinational legality check of a lane-positioned byte-enable mask.
//   Legal masks are the naturally aligned byte, halfword and word patterns.
//   Ports:
//     ByteEn : in  [3:0] lane mask
//     Legal  : out       1 when ByteEn is an aligned byte/half/word pattern
// -----------------------------------------------------------------------------
module byteEnChecker
    import HighLevelControl::*;
(
    input  logic [LANE_COUNT-1:0] ByteEn,
    output logic                  Legal
);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        Legal = 1'b0;
        case (ByteEn)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100,
            4'b1111: Legal = 1'b1;
            default: Legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/memory_bus_bridge.sv
// -----------------------------------------------------------------------------
// memory_bus_bridge
//   Turns the core's single-cycle data-memory port into a valid/ready request
//   plus response transaction on a variable-latency bus. The core is frozen
//   with Stall until the access retires; illegal masks, bus errors and
//   response timeouts abort the access with a one-cycle MemFault pulse.
//   Ports:
//     clk, reset                      : clock, synchronous active-low reset
//     MemEn, MemWrite, ByteEn,
//     MemAdr, MemWriteData            : core-side access request
//     MemReadData                     : registered load data to the core
//     Stall                           : core must hold while high
//     MemFault                        : one-cycle abort pulse
//     BusReqValid/BusReqReady         : request handshake
//     BusWrite, BusByteEn, BusAdr,
//     BusWriteData                    : registered request payload
//     BusRespValid, BusRespData,
//     BusRespError                    : response channel
// -----------------------------------------------------------------------------
module memory_bus_bridge
    import HighLevelControl::*;
#(
    parameter int BIT_COUNT      = 32,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemEn,
    input  logic                  MemWrite,
    input  logic [LANE_COUNT-1:0] ByteEn,
    input  logic [BIT_COUNT-1:0]  MemAdr,
    input  logic [DATA_WIDTH-1:0] MemWriteData,
    output logic [DATA_WIDTH-1:0] MemReadData,
    output logic                  Stall,
    output logic                  MemFault,
    output logic                  BusReqValid,
    input  logic                  BusReqReady,
    output logic                  BusWrite,
    output logic [LANE_COUNT-1:0] BusByteEn,
    output logic [BIT_COUNT-1:0]  BusAdr,
    output logic [DATA_WIDTH-1:0] BusWriteData,
    input  logic                  BusRespValid,
    input  logic [DATA_WIDTH-1:0] BusRespData,
    input  logic                  BusRespError
);

    localparam int                     COUNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VALUE = COUNT_WIDTH'(TIMEOUT_CYCLES);
    // Clears the two byte-offset bits to form a word address.
    localparam logic [BIT_COUNT-1:0]   WORD_MASK     = ~BIT_COUNT'(3);

    memBridgeState          state;
    memBridgeState          state_next;
    logic [COUNT_WIDTH-1:0] wait_count;
    logic                   byte_en_legal;

    byteEnChecker u_byte_en_checker (
        .ByteEn (ByteEn),
        .Legal  (byte_en_legal)
    );

    // Stall is combinational so the core sees it in the capture cycle itself;
    // it is forced low while reset is asserted.
    assign Stall = reset && MemEn &&
                   (state == IDLE || state == REQ || state == WAIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (MemEn) begin
                    state_next = byte_en_legal ? REQ : FAULT;
                end
            end
            // BusReqValid is high for the whole REQ state, so the ready
            // input alone completes the handshake.
            REQ: begin
                if (BusReqReady) begin
                    state_next = WAIT;
                end
            end
            // A response in the same cycle the counter expires still wins.
            WAIT: begin
                if (BusRespValid) begin
                    state_next = BusRespError ? FAULT : DONE;
                end else if (wait_count == TIMEOUT_VALUE) begin
                    state_next = FAULT;
                end
            end
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_count   <= '0;
            MemReadData  <= '0;
            MemFault     <= 1'b0;
            BusReqValid  <= 1'b0;
            BusWrite     <= 1'b0;
            BusByteEn    <= '0;
            BusAdr       <= '0;
            BusWriteData <= '0;
        end else begin
            // Registered from the next state so both flags line up exactly
            // with the REQ and FAULT states.
            BusReqValid <= (state_next == REQ);
            MemFault    <= (state_next == FAULT);

            if (state == IDLE && MemEn && byte_en_legal) begin
                BusWrite     <= MemWrite;
                BusByteEn    <= ByteEn;
                BusAdr       <= MemAdr & WORD_MASK;
                BusWriteData <= MemWriteData;
            end

            if (state == REQ && BusReqReady) begin
                wait_count <= '0;
            end else if (state == WAIT && !BusRespValid) begin
                wait_count <= wait_count + 1'b1;
            end

            // Stores leave the last load value untouched; any abort zeroes it.
            if (state == WAIT && BusRespValid && !BusRespError && !BusWrite) begin
                MemReadData <= BusRespData;
            end
            if (state_next == FAULT) begin
                MemReadData <= '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_memory_bus_bridge
//   Self-checking bench for memory_bus_bridge (BIT_COUNT=32, TIMEOUT_CYCLES=4).
//   Each access is described by its bus behaviour (ready delay, response delay,
//   error, timeout); the expected per-cycle outputs are derived from that
//   timeline with plain arithmetic and checked every cycle at the falling edge.
// -----------------------------------------------------------------------------
module tb_memory_bus_bridge;

    localparam int BIT_COUNT      = 32;
    localparam int TIMEOUT_CYCLES = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 MemEn;
    logic                 MemWrite;
    logic [3:0]           ByteEn;
    logic [BIT_COUNT-1:0] MemAdr;
    logic [31:0]          MemWriteData;
    logic [31:0]          MemReadData;
    logic                 Stall;
    logic                 MemFault;
    logic                 BusReqValid;
    logic                 BusReqReady;
    logic                 BusWrite;
    logic [3:0]           BusByteEn;
    logic [BIT_COUNT-1:0] BusAdr;
    logic [31:0]          BusWriteData;
    logic                 BusRespValid;
    logic [31:0]          BusRespData;
    logic                 BusRespError;

    always #5 clk = ~clk;

    memory_bus_bridge #(
        .BIT_COUNT      (BIT_COUNT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemEn        (MemEn),
        .MemWrite     (MemWrite),
        .ByteEn       (ByteEn),
        .MemAdr       (MemAdr),
        .MemWriteData (MemWriteData),
        .MemReadData  (MemReadData),
        .Stall        (Stall),
        .MemFault     (MemFault),
        .BusReqValid  (BusReqValid),
        .BusReqReady  (BusReqReady),
        .BusWrite     (BusWrite),
        .BusByteEn    (BusByteEn),
        .BusAdr       (BusAdr),
        .BusWriteData (BusWriteData),
        .BusRespValid (BusRespValid),
        .BusRespData  (BusRespData),
        .BusRespError (BusRespError)
    );

    int total = 0;
    int bad   = 0;

    // Expected outputs for the current cycle.
    bit          chk_en = 1'b0;
    bit          e_stall, e_valid, e_fault, e_bus;
    logic [31:0] e_rd, e_adr, e_wdata;
    logic        e_wr;
    logic [3:0]  e_be;

    // Model of the core-visible load register.
    logic [31:0] rd_model = '0;

    // Observed per-access event counts.
    int stall_cnt, valid_cnt, hs_cnt, fault_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall",     64'(Stall),       64'(e_stall));
            check("req_valid", 64'(BusReqValid), 64'(e_valid));
            check("mem_fault", 64'(MemFault),    64'(e_fault));
            check("read_data", 64'(MemReadData), 64'(e_rd));
            if (e_bus) begin
                check("bus_adr",   64'(BusAdr),       64'(e_adr));
                check("bus_write", 64'(BusWrite),     64'(e_wr));
                check("bus_be",    64'(BusByteEn),    64'(e_be));
                check("bus_wdata", 64'(BusWriteData), 64'(e_wdata));
            end
            if (Stall)                      stall_cnt++;
            if (BusReqValid)                valid_cnt++;
            if (BusReqValid && BusReqReady) hs_cnt++;
            if (MemFault)                   fault_cnt++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One core access. d_r: cycles the bus holds ready low; d_s: WAIT cycles
    // before the response (beyond TIMEOUT_CYCLES means no response at all);
    // abort_k: cycle index at which reset is pulsed low (-1 for none).
    task automatic access(input logic wr, input logic [3:0] be, input logic [31:0] adr,
                          input logic [31:0] wdata, input int d_r, input int d_s,
                          input logic err, input logic [31:0] rdata, input int abort_k);
        bit          legal, responded, fault, in_req, in_wait;
        int          w0, e;
        logic [31:0] rd_new;
        legal     = be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        w0        = 2 + d_r;
        responded = legal && (d_s <= TIMEOUT_CYCLES);
        if (!legal) begin
            e = 1; fault = 1'b1;
        end else if (responded) begin
            e = w0 + d_s + 1; fault = err;
        end else begin
            e = w0 + TIMEOUT_CYCLES + 1; fault = 1'b1;
        end
        rd_new = fault ? 32'h0 : (wr ? rd_model : rdata);
        stall_cnt = 0; valid_cnt = 0; hs_cnt = 0; fault_cnt = 0;
        for (int k = 0; k <= e; k++) begin
            MemEn = 1'b1; MemWrite = wr; ByteEn = be; MemAdr = adr; MemWriteData = wdata;
            in_req  = legal && k >= 1 && k <= 1 + d_r;
            in_wait = legal && k >= w0 && k < e;
            BusReqReady = in_req ? (k == 1 + d_r) : 1'($urandom);
            if (in_wait) begin
                BusRespValid = responded && (k == w0 + d_s);
                BusRespError = err;
                BusRespData  = rdata;
            end else begin
                BusRespValid = 1'($urandom);
                BusRespError = 1'($urandom);
                BusRespData  = $urandom;
            end
            e_valid = in_req; e_bus = in_req;
            e_adr = adr & ~32'h3; e_wr = wr; e_be = be; e_wdata = wdata;
            e_stall = (k < e);
            e_fault = (k == e) && fault;
            e_rd    = (k == e) ? rd_new : rd_model;
            if (k == abort_k) begin
                reset = 1'b0; e_stall = 1'b0; e_fault = 1'b0; e_rd = rd_model;
            end
            next_cycle();
            if (k == abort_k) begin
                reset = 1'b1;
                rd_model = '0;
                return;
            end
        end
        rd_model = rd_new;
    endtask

    // A cycle with no core request; stale forces a response onto the bus.
    task automatic idle(input bit stale);
        MemEn = 1'b0; MemWrite = 1'($urandom); ByteEn = 4'($urandom);
        MemAdr = $urandom; MemWriteData = $urandom;
        BusReqReady  = 1'($urandom);
        BusRespValid = stale ? 1'b1 : 1'($urandom);
        BusRespError = stale ? 1'b0 : 1'($urandom);
        BusRespData  = $urandom;
        e_valid = 1'b0; e_bus = 1'b0; e_stall = 1'b0; e_fault = 1'b0; e_rd = rd_model;
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] legal_list [7];
        logic [3:0] be;
        int         d_s;
        legal_list = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

        // Reset with MemEn held high: Stall must stay low and all outputs zero.
        reset = 1'b0; MemEn = 1'b1; MemWrite = 1'b1; ByteEn = 4'hF;
        MemAdr = 32'h1234; MemWriteData = 32'h5555_5555;
        BusReqReady = 1'b1; BusRespValid = 1'b0; BusRespError = 1'b0; BusRespData = '0;
        next_cycle();
        e_stall = 1'b0; e_valid = 1'b0; e_fault = 1'b0; e_rd = '0;
        e_bus = 1'b1; e_adr = '0; e_wr = 1'b0; e_be = '0; e_wdata = '0;
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        idle(0);

        // Load, immediate ready, response one cycle after the handshake.
        access(1'b0, 4'hF, 32'h100, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, -1);
        check("load_stall_cycles", 64'(stall_cnt), 64'd3);
        check("load_handshakes",   64'(hs_cnt),    64'd1);
        check("load_read_data",    64'(MemReadData), 64'hDEAD_BEEF);
        idle(0);

        // Store with ready held low for 4 cycles.
        access(1'b1, 4'b1000, 32'h203, 32'hAA00_0000, 4, 0, 1'b0, 32'h0BAD_0BAD, -1);
        check("store_valid_cycles", 64'(valid_cnt), 64'd5);
        check("store_no_fault",     64'(fault_cnt), 64'd0);
        check("store_read_data",    64'(MemReadData), 64'hDEAD_BEEF);
        idle(0);

        // Illegal mask: no bus request, fault pulse one cycle later.
        access(1'b0, 4'b0101, 32'h44, 32'h0, 0, 0, 1'b0, 32'h0, -1);
        check("illegal_valid_cycles", 64'(valid_cnt), 64'd0);
        check("illegal_fault_pulses", 64'(fault_cnt), 64'd1);
        check("illegal_read_data",    64'(MemReadData), 64'h0);
        idle(0);

        // Timeout: no response; a late response afterwards is ignored.
        access(1'b0, 4'hF, 32'h40, 32'h0, 1, TIMEOUT_CYCLES + 1, 1'b0, 32'h0, -1);
        check("timeout_stall_cycles", 64'(stall_cnt), 64'd8);
        check("timeout_fault_pulses", 64'(fault_cnt), 64'd1);
        idle(1);
        idle(0);

        // Good load followed by a bus error.
        access(1'b0, 4'b0011, 32'h8, 32'h0, 0, 1, 1'b0, 32'h1234_5678, -1);
        check("half_read_data", 64'(MemReadData), 64'h1234_5678);
        access(1'b0, 4'b1100, 32'hA, 32'h0, 0, 2, 1'b1, 32'hFFFF_FFFF, -1);
        check("error_fault_pulses", 64'(fault_cnt), 64'd1);
        check("error_read_data",    64'(MemReadData), 64'h0);

        // Reset pulsed during WAIT, then a stale response.
        access(1'b0, 4'hF, 32'h20, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D, -1);
        access(1'b0, 4'hF, 32'h300, 32'h0, 0, 3, 1'b0, 32'h7777_7777, 3);
        check("abort_read_data", 64'(MemReadData), 64'h0);
        idle(0);
        idle(1);
        idle(0);

        // Randomized accesses, some back-to-back, some with timeouts or errors.
        for (int n = 0; n < 80; n++) begin
            be  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_list[$urandom_range(0, 6)];
            d_s = $urandom_range(0, TIMEOUT_CYCLES + 2);
            access(1'($urandom), be, $urandom, $urandom, $urandom_range(0, 3), d_s,
                   ($urandom_range(0, 5) == 0), $urandom, -1);
            if ($urandom_range(0, 1) == 0) begin
                for (int j = 0; j < $urandom_range(1, 2); j++) idle(0);
            end
        end
        idle(0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
